w0rm_alu_writeback: RTL and testbench

// Downstream stage of the W0RM ALU units, starting with AddSub. Pairs each ALU result with the

---
 rtl/w0rm_alu_writeback.sv | 139 +++++++++++++
 tb/tb_w0rm_alu_writeback.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/w0rm_alu_writeback.sv
// w0rm_alu_writeback
// Writeback stage behind the W0RM ALU units. When an op issues, its destination tag
// {dest, set_flags} is queued. Each ALU result pops the oldest tag, and the paired entry
// goes into a result buffer. The buffer drains in order to the register-file write port
// and applies backpressure. Issue credits bound in-flight plus buffered ops to DEPTH, so a
// stalled register file never forces a result to be dropped.
//
// Ports
//   clk_i, reset_i            clock (rising edge), async active-high reset
//   issue_valid_i/_dest_i/_set_flags_i, issue_ready_o   issue side (credit = issue_ready_o)
//   result_valid_i/result_i/result_flags_i               ALU result strobe and payload
//   rf_we_o/rf_addr_o/rf_data_o, rf_ready_i              show-ahead register-file write port
//   flags_out_o                architectural flags, updated in writeback order
//   pending_o                  ops issued but not yet written back
//   tag_error_o                sticky: result arrived with no outstanding tag
module w0rm_alu_writeback #(
    parameter int DATA_WIDTH     = 8,
    parameter int FLAGS_WIDTH    = 4,
    parameter int REG_ADDR_WIDTH = 4,
    parameter int DEPTH          = 4
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic                         issue_valid_i,
    input  logic [REG_ADDR_WIDTH-1:0]    issue_dest_i,
    input  logic                         issue_set_flags_i,
    output logic                         issue_ready_o,
    input  logic                         result_valid_i,
    input  logic [DATA_WIDTH-1:0]        result_i,
    input  logic [FLAGS_WIDTH-1:0]       result_flags_i,
    output logic                         rf_we_o,
    output logic [REG_ADDR_WIDTH-1:0]    rf_addr_o,
    output logic [DATA_WIDTH-1:0]        rf_data_o,
    input  logic                         rf_ready_i,
    output logic [FLAGS_WIDTH-1:0]       flags_out_o,
    output logic [$clog2(DEPTH):0]       pending_o,
    output logic                         tag_error_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = REG_ADDR_WIDTH + 1;
    localparam int EW = TW + DATA_WIDTH + FLAGS_WIDTH;

    logic [TW-1:0] tag_mem_q [DEPTH];
    logic [AW-1:0] tag_wr_q, tag_rd_q;
    logic [CW-1:0] tag_cnt_q;

    logic [EW-1:0] res_mem_q [DEPTH];
    logic [AW-1:0] res_wr_q, res_rd_q;
    logic [CW-1:0] res_cnt_q;

    logic [EW-1:0]          head_q, head_d;
    logic                   rf_we_q, rf_we_d;
    logic [CW-1:0]          pending_q;
    logic [FLAGS_WIDTH-1:0] flags_q;
    logic                   tag_err_q;

    logic          issue_push_s, tag_pop_s, xfer_s;
    logic [EW-1:0] push_entry_s;
    logic [AW-1:0] res_rd_d;
    logic [CW-1:0] res_cnt_d, remain_s;

    // Credit is derived from registered pending only; a drain in this cycle does not free a slot early.
    assign issue_ready_o = (pending_q < CW'(DEPTH));
    assign issue_push_s  = issue_valid_i & issue_ready_o;
    // Tag count is registered, so a tag pushed this cycle cannot be popped until next cycle.
    assign tag_pop_s     = result_valid_i & (tag_cnt_q != {CW{1'b0}});
    assign xfer_s        = rf_we_q & rf_ready_i;
    assign push_entry_s  = {tag_mem_q[tag_rd_q], result_i, result_flags_i};

    // Next show-ahead head entry of the result buffer and next write-valid.
    always_comb begin
        res_rd_d  = res_rd_q + AW'(xfer_s);
        res_cnt_d = res_cnt_q + CW'(tag_pop_s) - CW'(xfer_s);
        remain_s  = res_cnt_q - CW'(xfer_s);
        head_d    = head_q;
        if (remain_s == {CW{1'b0}}) begin
            // Buffer would be empty: the incoming entry (if any) becomes the head directly.
            if (tag_pop_s) begin
                head_d = push_entry_s;
            end else begin
                head_d = head_q;
            end
        end else begin
            head_d = res_mem_q[res_rd_d];
        end
        rf_we_d = (res_cnt_d != {CW{1'b0}});
    end

    // Queue storage; only pointers and counts need reset.
    always_ff @(posedge clk_i) begin
        if (issue_push_s) begin
            tag_mem_q[tag_wr_q] <= {issue_dest_i, issue_set_flags_i};
        end
        if (tag_pop_s) begin
            res_mem_q[res_wr_q] <= push_entry_s;
        end
    end

    // Pointers, counts, registered write port, flags and error state.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            tag_wr_q  <= {AW{1'b0}};
            tag_rd_q  <= {AW{1'b0}};
            tag_cnt_q <= {CW{1'b0}};
            res_wr_q  <= {AW{1'b0}};
            res_rd_q  <= {AW{1'b0}};
            res_cnt_q <= {CW{1'b0}};
            head_q    <= {EW{1'b0}};
            rf_we_q   <= 1'b0;
            pending_q <= {CW{1'b0}};
            flags_q   <= {FLAGS_WIDTH{1'b0}};
            tag_err_q <= 1'b0;
        end else begin
            tag_wr_q  <= tag_wr_q + AW'(issue_push_s);
            tag_rd_q  <= tag_rd_q + AW'(tag_pop_s);
            tag_cnt_q <= tag_cnt_q + CW'(issue_push_s) - CW'(tag_pop_s);
            res_wr_q  <= res_wr_q + AW'(tag_pop_s);
            res_rd_q  <= res_rd_d;
            res_cnt_q <= res_cnt_d;
            head_q    <= head_d;
            rf_we_q   <= rf_we_d;
            pending_q <= pending_q + CW'(issue_push_s) - CW'(xfer_s);
            if (xfer_s && head_q[DATA_WIDTH+FLAGS_WIDTH]) begin
                flags_q <= head_q[FLAGS_WIDTH-1:0];
            end
            if (result_valid_i && !tag_pop_s) begin
                tag_err_q <= 1'b1;
            end
        end
    end

    assign rf_we_o     = rf_we_q;
    assign rf_addr_o   = head_q[EW-1 -: REG_ADDR_WIDTH];
    assign rf_data_o   = head_q[FLAGS_WIDTH +: DATA_WIDTH];
    assign flags_out_o = flags_q;
    assign pending_o   = pending_q;
    assign tag_error_o = tag_err_q;
endmodule

// File: tb/tb_w0rm_alu_writeback.sv
module tb_w0rm_alu_writeback;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset_i;
    logic       issue_valid_i, issue_set_flags_i, result_valid_i, rf_ready_i;
    logic [3:0] issue_dest_i, result_flags_i;
    logic [7:0] result_i;
    logic       issue_ready_o, rf_we_o, tag_error_o;
    logic [3:0] rf_addr_o, flags_out_o;
    logic [7:0] rf_data_o;
    logic [2:0] pending_o;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [3:0] dest;
        logic       sf;
        logic [7:0] data;
        logic [3:0] fl;
    } ent_t;

    // Reference model: the outstanding tags and the buffered results, in issue order.
    ent_t tq[$];
    ent_t rq[$];
    int         m_pend;
    logic [3:0] m_flags;
    logic       m_terr;

    always #5 clk = ~clk;

    w0rm_alu_writeback #(.DATA_WIDTH(8), .FLAGS_WIDTH(4), .REG_ADDR_WIDTH(4), .DEPTH(DEPTH)) dut (
        .clk_i(clk), .reset_i(reset_i),
        .issue_valid_i(issue_valid_i), .issue_dest_i(issue_dest_i),
        .issue_set_flags_i(issue_set_flags_i), .issue_ready_o(issue_ready_o),
        .result_valid_i(result_valid_i), .result_i(result_i), .result_flags_i(result_flags_i),
        .rf_we_o(rf_we_o), .rf_addr_o(rf_addr_o), .rf_data_o(rf_data_o), .rf_ready_i(rf_ready_i),
        .flags_out_o(flags_out_o), .pending_o(pending_o), .tag_error_o(tag_error_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic m_reset();
        tq.delete();
        rq.delete();
        m_pend  = 0;
        m_flags = 4'd0;
        m_terr  = 1'b0;
    endtask

    task automatic check_all(input string where);
        chk({where, ".rf_we"}, 32'(rf_we_o), 32'(rq.size() != 0));
        if (rq.size() != 0) begin
            chk({where, ".rf_addr"}, 32'(rf_addr_o), 32'(rq[0].dest));
            chk({where, ".rf_data"}, 32'(rf_data_o), 32'(rq[0].data));
        end
        chk({where, ".flags"}, 32'(flags_out_o), 32'(m_flags));
        chk({where, ".pending"}, 32'(pending_o), 32'(m_pend));
        chk({where, ".issue_ready"}, 32'(issue_ready_o), 32'(m_pend < DEPTH));
        chk({where, ".tag_error"}, 32'(tag_error_o), 32'(m_terr));
    endtask

    // One clock cycle: drive inputs, advance the model at the edge, compare after the edge.
    task automatic step(input string where, input logic iv, input logic [3:0] idest, input logic isf,
                        input logic rv, input logic [7:0] rdata, input logic [3:0] rfl, input logic rr);
        bit   xfer, tpop, ipush;
        ent_t e;
        issue_valid_i = iv; issue_dest_i = idest; issue_set_flags_i = isf;
        result_valid_i = rv; result_i = rdata; result_flags_i = rfl; rf_ready_i = rr;
        xfer  = (rq.size() != 0) && rr;
        tpop  = rv && (tq.size() != 0);
        ipush = iv && (m_pend < DEPTH);
        @(posedge clk);
        if (reset_i) begin
            m_reset();
        end else begin
            if (xfer) begin
                e = rq.pop_front();
                if (e.sf) m_flags = e.fl;
            end
            if (tpop) begin
                e = tq.pop_front();
                e.data = rdata;
                e.fl   = rfl;
                rq.push_back(e);
            end else if (rv) begin
                m_terr = 1'b1;
            end
            if (ipush) begin
                e = '0;
                e.dest = idest;
                e.sf   = isf;
                tq.push_back(e);
            end
            m_pend = m_pend + int'(ipush) - int'(xfer);
        end
        #1;
        check_all(where);
    endtask

    task automatic idle(input string where, input logic rr);
        step(where, 1'b0, 4'd0, 1'b0, 1'b0, 8'd0, 4'd0, rr);
    endtask

    task automatic drain(input string where);
        for (int i = 0; i < 12; i++) begin
            step(where, 1'b0, 4'd0, 1'b0, tq.size() != 0, 8'($urandom), 4'($urandom), 1'b1);
        end
    endtask

    initial begin
        reset_i = 1'b1;
        issue_valid_i = 1'b0; issue_dest_i = 4'd0; issue_set_flags_i = 1'b0;
        result_valid_i = 1'b0; result_i = 8'd0; result_flags_i = 4'd0; rf_ready_i = 1'b0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        chk("reset.rf_addr", 32'(rf_addr_o), 32'd0);
        chk("reset.rf_data", 32'(rf_data_o), 32'd0);
        reset_i = 1'b0;

        // 1: single op, result two cycles after issue
        step("t1.issue", 1'b1, 4'd3, 1'b1, 1'b0, 8'd0, 4'd0, 1'b1);
        chk("t1.pending1", 32'(pending_o), 32'd1);
        idle("t1.wait", 1'b1);
        step("t1.result", 1'b0, 4'd0, 1'b0, 1'b1, 8'h7F, 4'b0010, 1'b1);
        chk("t1.we", 32'(rf_we_o), 32'd1);
        chk("t1.addr", 32'(rf_addr_o), 32'd3);
        chk("t1.data", 32'(rf_data_o), 32'h7F);
        idle("t1.write", 1'b1);
        chk("t1.flags", 32'(flags_out_o), 32'b0010);
        chk("t1.pending0", 32'(pending_o), 32'd0);

        // 2: stalled register file, credits exhausted, then back-to-back writes
        for (int i = 1; i <= 4; i++) begin
            step("t2.issue", 1'b1, 4'(i), 1'b0, tq.size() != 0, 8'(8'h10 + i), 4'd0, 1'b0);
        end
        chk("t2.ready0", 32'(issue_ready_o), 32'd0);
        chk("t2.pending4", 32'(pending_o), 32'd4);
        for (int i = 0; i < 4; i++) begin
            step("t2.hold", 1'b0, 4'd0, 1'b0, tq.size() != 0, 8'h44, 4'd0, 1'b0);
        end
        chk("t2.holdaddr", 32'(rf_addr_o), 32'd1);
        idle("t2.w1", 1'b1);
        chk("t2.ready1", 32'(issue_ready_o), 32'd1);
        chk("t2.addr2", 32'(rf_addr_o), 32'd2);
        drain("t2.drain");

        // 3: op that does not set flags leaves flags_out alone
        step("t3.i1", 1'b1, 4'd5, 1'b1, 1'b0, 8'd0, 4'd0, 1'b1);
        step("t3.i2", 1'b1, 4'd6, 1'b0, 1'b1, 8'hA1, 4'b0001, 1'b1);
        step("t3.r2", 1'b0, 4'd0, 1'b0, 1'b1, 8'hA2, 4'b1111, 1'b1);
        drain("t3.drain");
        chk("t3.flags", 32'(flags_out_o), 32'b0001);

        // 4: result with no outstanding tag
        step("t4.orphan", 1'b0, 4'd0, 1'b0, 1'b1, 8'h55, 4'hF, 1'b1);
        chk("t4.terr", 32'(tag_error_o), 32'd1);
        chk("t4.we", 32'(rf_we_o), 32'd0);
        chk("t4.pending", 32'(pending_o), 32'd0);
        idle("t4.sticky", 1'b1);

        // 5a: continuous traffic across pointer wrap
        for (int i = 0; i < 3 * DEPTH + 4; i++) begin
            step("t5.stream", (i < 3 * DEPTH) && (m_pend < DEPTH), 4'($urandom), 1'($urandom),
                 tq.size() != 0, 8'($urandom), 4'($urandom), 1'b1);
        end
        drain("t5.drain");

        // 5b: issue and drain in the same cycle at pending = DEPTH-1
        for (int i = 0; i < DEPTH - 1; i++) begin
            step("t5.fill", 1'b1, 4'(i + 8), 1'b1, tq.size() != 0, 8'(i + 8'hC0), 4'(i), 1'b0);
        end
        step("t5.res", 1'b0, 4'd0, 1'b0, 1'b1, 8'hCF, 4'd7, 1'b0);
        chk("t5.pend3", 32'(pending_o), 32'(DEPTH - 1));
        step("t5.both", 1'b1, 4'd12, 1'b0, 1'b0, 8'd0, 4'd0, 1'b1);
        chk("t5.pendsame", 32'(pending_o), 32'(DEPTH - 1));
        drain("t5.drain2");

        // Randomized traffic against the model
        for (int i = 0; i < 300; i++) begin
            step("rand", ($urandom % 2 == 0) && (m_pend < DEPTH), 4'($urandom), 1'($urandom),
                 ($urandom % 2 == 0) && (tq.size() != 0), 8'($urandom), 4'($urandom),
                 ($urandom % 4) != 0);
        end
        drain("rand.drain");

        // 6: asynchronous reset with two buffered and one in flight, then a late result
        for (int i = 0; i < 3; i++) begin
            step("t6.issue", 1'b1, 4'(i + 1), 1'b1, tq.size() != 0, 8'(i + 8'h30), 4'(i + 1), 1'b0);
        end
        chk("t6.pend", 32'(pending_o), 32'd3);
        #2;
        reset_i = 1'b1;
        m_reset();
        #1;
        check_all("t6.async");
        chk("t6.rf_addr", 32'(rf_addr_o), 32'd0);
        chk("t6.rf_data", 32'(rf_data_o), 32'd0);
        idle("t6.held", 1'b1);
        reset_i = 1'b0;
        step("t6.late", 1'b0, 4'd0, 1'b0, 1'b1, 8'h99, 4'h9, 1'b1);
        chk("t6.terr", 32'(tag_error_o), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
